// File: rtl/frame_mem_arb.sv
// Shares one DRAM burst port between the frame read DMA and the frame write DMA, one burst at a time.
// Reads win by default; after RD_STREAK_MAX back-to-back reads with a write waiting, the write is granted.
// Define FRAME_MEM_ARB_STATS_EN to add the per-direction burst counters stat_rd_bursts/stat_wr_bursts.
module frame_mem_arb #(
  parameter int RD_STREAK_MAX = 4,
  parameter int LEN_W         = 8
) (
  input  logic             fclk,
  input  logic             rst,
  input  logic             rd_req,
  input  logic [31:0]      rd_addr,
  input  logic [LEN_W-1:0] rd_len,
  output logic             rd_ack,
  output logic             rd_done,
  input  logic             wr_req,
  input  logic [31:0]      wr_addr,
  input  logic [LEN_W-1:0] wr_len,
  output logic             wr_ack,
  output logic             wr_done,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic             cmd_write,
  output logic [31:0]      cmd_addr,
  output logic [LEN_W-1:0] cmd_len,
  input  logic             mem_done,
  output logic             err_spurious,
  output logic [1:0]       debug_state
`ifdef FRAME_MEM_ARB_STATS_EN
  ,
  output logic [31:0]      stat_rd_bursts,
  output logic [31:0]      stat_wr_bursts
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } state_t;

  localparam logic [7:0] STREAK_MAX = 8'(RD_STREAK_MAX);

  state_t           state_reg;
  logic [7:0]       streak_reg;
  logic             owner_reg;      // 0 = read DMA, 1 = write DMA
  logic             cmd_valid_reg;
  logic [31:0]      cmd_addr_reg;
  logic [LEN_W-1:0] cmd_len_reg;
  logic             err_reg;

  logic             grant_wr;
  logic             issue_fire;
  logic             burst_end;
  logic [1:0]       ack_vec;
  logic [1:0]       done_vec;

  // A waiting write only loses to a read until the read streak hits its cap.
  assign grant_wr   = wr_req && (!rd_req || (streak_reg == STREAK_MAX));
  assign issue_fire = (state_reg == ISSUE) && cmd_valid_reg && cmd_ready;
  assign burst_end  = (state_reg == BUSY) && mem_done;

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      streak_reg    <= 8'd0;
      owner_reg     <= 1'b0;
      cmd_valid_reg <= 1'b0;
      cmd_addr_reg  <= 32'd0;
      cmd_len_reg   <= '0;
      err_reg       <= 1'b0;
    end else begin
      if (mem_done && (state_reg != BUSY))
        err_reg <= 1'b1;

      case (state_reg)
        IDLE: begin
          if (rd_req || wr_req) begin
            owner_reg     <= grant_wr;
            cmd_addr_reg  <= grant_wr ? wr_addr : rd_addr;
            cmd_len_reg   <= grant_wr ? wr_len : rd_len;
            cmd_valid_reg <= 1'b1;
            state_reg     <= ISSUE;
            if (grant_wr || !wr_req)
              streak_reg <= 8'd0;
            else if (streak_reg != STREAK_MAX)
              streak_reg <= streak_reg + 8'd1;
          end
        end
        ISSUE: begin
          if (cmd_ready) begin
            cmd_valid_reg <= 1'b0;
            state_reg     <= BUSY;
          end
        end
        BUSY: begin
          if (mem_done)
            state_reg <= IDLE;
        end
        default: begin
          cmd_valid_reg <= 1'b0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  // Index 0 is the read requester, index 1 the write requester.
  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    localparam logic OWN = (gi == 1);
    assign ack_vec[gi]  = issue_fire && (owner_reg == OWN);
    assign done_vec[gi] = burst_end && (owner_reg == OWN);
  end

  assign rd_ack       = ack_vec[0];
  assign wr_ack       = ack_vec[1];
  assign rd_done      = done_vec[0];
  assign wr_done      = done_vec[1];
  assign cmd_valid    = cmd_valid_reg;
  assign cmd_write    = owner_reg;
  assign cmd_addr     = cmd_addr_reg;
  assign cmd_len      = cmd_len_reg;
  assign err_spurious = err_reg;
  assign debug_state  = state_reg;

`ifdef FRAME_MEM_ARB_STATS_EN
  logic [31:0] stat_reg [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_stat
    always_ff @(posedge fclk or posedge rst) begin
      if (rst)
        stat_reg[gi] <= 32'd0;
      else if (done_vec[gi])
        stat_reg[gi] <= stat_reg[gi] + 32'd1;
    end
  end

  assign stat_rd_bursts = stat_reg[0];
  assign stat_wr_bursts = stat_reg[1];
`endif

endmodule

// File: tb/tb_frame_mem_arb.sv
// Scoreboard bench for frame_mem_arb: stimulus pushes expected commands/completions, a negedge monitor checks them.
// Build with FRAME_MEM_ARB_STATS_EN defined to also exercise the burst counters.
module tb_frame_mem_arb;

  logic        fclk;
  logic        rst;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic [7:0]  rd_len;
  logic        rd_ack;
  logic        rd_done;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [7:0]  wr_len;
  logic        wr_ack;
  logic        wr_done;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        mem_done;
  logic        err_spurious;
  logic [1:0]  debug_state;
`ifdef FRAME_MEM_ARB_STATS_EN
  logic [31:0] stat_rd_bursts;
  logic [31:0] stat_wr_bursts;
`endif

  frame_mem_arb #(.RD_STREAK_MAX(4), .LEN_W(8)) dut (
    .fclk(fclk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_ack(rd_ack), .rd_done(rd_done),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_ack(wr_ack), .wr_done(wr_done),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .mem_done(mem_done),
    .err_spurious(err_spurious), .debug_state(debug_state)
`ifdef FRAME_MEM_ARB_STATS_EN
    , .stat_rd_bursts(stat_rd_bursts), .stat_wr_bursts(stat_wr_bursts)
`endif
  );

  typedef struct packed {
    bit          wr;
    logic [31:0] addr;
    logic [7:0]  len;
  } cmd_t;

  cmd_t exp_cmd_q[$];
  bit   exp_done_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  initial begin
    fclk = 1'b0;
    forever #5 fclk = ~fclk;
  end

  always @(posedge fclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_cmd(input bit w, input logic [31:0] a, input logic [7:0] l);
    cmd_t c;
    c.wr   = w;
    c.addr = a;
    c.len  = l;
    exp_cmd_q.push_back(c);
  endtask

  // Called at posedge+1; returns at posedge+1 right after the command handshake.
  task automatic serve_issue();
    bit found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (cmd_valid && cmd_ready) begin
        found = 1'b1;
        break;
      end
      @(posedge fclk); #1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout: cmd_valid=%0b cmd_ready=%0b, required handshake within 50 cycles",
               cmd_valid, cmd_ready);
    end else begin
      @(posedge fclk); #1;
    end
  endtask

  // Called in BUSY at posedge+1; pulses mem_done after d idle BUSY cycles.
  task automatic serve_done(input bit exp_wr, input int d);
    chk("busy_state", debug_state, 2);
    chk("busy_cmd_valid", cmd_valid, 0);
    repeat (d) begin
      @(posedge fclk); #1;
    end
    exp_done_q.push_back(exp_wr);
    mem_done = 1'b1;
    @(posedge fclk); #1;
    mem_done = 1'b0;
  endtask

  // Monitor: every ack/done the DUT presents is matched against the scoreboard queues.
  initial begin
    cmd_t e;
    bit   ew;
    forever begin
      @(negedge fclk);
      if (rd_ack || wr_ack) begin
        if (exp_cmd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: rd_ack=%0b wr_ack=%0b, required no ack", rd_ack, wr_ack);
        end else begin
          e = exp_cmd_q.pop_front();
          $display("ack  %s addr=0x%08h len=%0d", cmd_write ? "WR" : "RD", cmd_addr, cmd_len);
          chk("ack_wr", wr_ack, e.wr);
          chk("ack_rd", rd_ack, !e.wr);
          chk("cmd_write", cmd_write, e.wr);
          chk("cmd_addr", cmd_addr, e.addr);
          chk("cmd_len", cmd_len, e.len);
          chk("cmd_valid_at_ack", cmd_valid, 1);
        end
      end
      if (rd_done || wr_done) begin
        if (exp_done_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: rd_done=%0b wr_done=%0b, required no done", rd_done, wr_done);
        end else begin
          ew = exp_done_q.pop_front();
          $display("done %s", wr_done ? "WR" : "RD");
          chk("done_wr", wr_done, ew);
          chk("done_rd", rd_done, !ew);
        end
      end
    end
  end

  initial begin
    int t0;
    rst = 1'b1;
    rd_req = 1'b0; rd_addr = 32'd0; rd_len = 8'd0;
    wr_req = 1'b0; wr_addr = 32'd0; wr_len = 8'd0;
    cmd_ready = 1'b0; mem_done = 1'b0;

    // Reset state
    repeat (3) @(posedge fclk);
    @(negedge fclk);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_state", debug_state, 0);
    chk("rst_err", err_spurious, 0);
    chk("rst_acks", {rd_ack, wr_ack, rd_done, wr_done}, 0);
    chk("rst_cmd_addr", cmd_addr, 0);
    @(posedge fclk); #1;
    rst = 1'b0;

    // 1: single read, latency of one cycle from request to cmd_valid
    push_cmd(1'b0, 32'h0000_1000, 8'd15);
    rd_addr = 32'h0000_1000; rd_len = 8'd15; cmd_ready = 1'b1; rd_req = 1'b1;
    @(negedge fclk);
    chk("t1_valid_before_grant", cmd_valid, 0);
    @(negedge fclk);
    chk("t1_valid_after_grant", cmd_valid, 1);
    chk("t1_state_issue", debug_state, 1);
    serve_issue();
    rd_req = 1'b0;
    serve_done(1'b0, 5);

    // 2: both requesters held; streak cap of 4 lets every fifth grant go to the write
    rd_addr = 32'h0000_2000; rd_len = 8'd3;
    wr_addr = 32'h0000_8000; wr_len = 8'd7;
    for (int i = 0; i < 10; i++) begin
      if ((i % 5) == 4) push_cmd(1'b1, 32'h0000_8000, 8'd7);
      else              push_cmd(1'b0, 32'h0000_2000, 8'd3);
    end
    rd_req = 1'b1; wr_req = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 10; i++) begin
      serve_issue();
      if (i == 9) begin
        rd_req = 1'b0;
        wr_req = 1'b0;
      end
      serve_done((i % 5) == 4, 0);
    end
    chk("t2_cycles", cyc - t0, 30);

    // 3: memory stalls ten cycles in ISSUE
    push_cmd(1'b0, 32'h0000_3000, 8'h22);
    cmd_ready = 1'b0;
    rd_addr = 32'h0000_3000; rd_len = 8'h22; rd_req = 1'b1;
    @(posedge fclk); #1;
    for (int k = 0; k < 10; k++) begin
      @(negedge fclk);
      chk("t3_stall_valid", cmd_valid, 1);
      chk("t3_stall_addr", cmd_addr, 32'h0000_3000);
      chk("t3_stall_len", cmd_len, 8'h22);
      chk("t3_stall_no_ack", rd_ack, 0);
      @(posedge fclk); #1;
    end
    cmd_ready = 1'b1;
    serve_issue();
    rd_req = 1'b0;
    serve_done(1'b0, 2);

    // 4: spurious mem_done in IDLE sets the sticky flag; traffic still flows
    mem_done = 1'b1;
    @(negedge fclk);
    chk("t4_no_done", {rd_done, wr_done}, 0);
    @(posedge fclk); #1;
    mem_done = 1'b0;
    chk("t4_err_set", err_spurious, 1);
    push_cmd(1'b1, 32'h0000_9000, 8'd1);
    wr_addr = 32'h0000_9000; wr_len = 8'd1; wr_req = 1'b1;
    serve_issue();
    wr_req = 1'b0;
    serve_done(1'b1, 1);
    chk("t4_err_sticky", err_spurious, 1);

    // 5: reset while a write burst is outstanding
    push_cmd(1'b1, 32'h0000_A000, 8'd2);
    wr_addr = 32'h0000_A000; wr_len = 8'd2; wr_req = 1'b1;
    serve_issue();
    wr_req = 1'b0;
    chk("t5_in_busy", debug_state, 2);
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", cmd_valid, 0);
    chk("t5_rst_state", debug_state, 0);
    chk("t5_rst_err", err_spurious, 0);
    @(negedge fclk);
    chk("t5_no_wr_done", wr_done, 0);
    @(posedge fclk); #1;
    rst = 1'b0;
    push_cmd(1'b0, 32'h0000_4000, 8'd4);
    rd_addr = 32'h0000_4000; rd_len = 8'd4; rd_req = 1'b1;
    serve_issue();
    rd_req = 1'b0;
    serve_done(1'b0, 0);

`ifdef FRAME_MEM_ARB_STATS_EN
    // 6: burst counters
    rst = 1'b1;
    @(posedge fclk); #1;
    rst = 1'b0;
    chk("t6_rd_cleared", stat_rd_bursts, 0);
    chk("t6_wr_cleared", stat_wr_bursts, 0);
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin
        push_cmd(1'b0, 32'h0001_0000 + 32'(i), 8'(i));
        rd_addr = 32'h0001_0000 + 32'(i); rd_len = 8'(i); rd_req = 1'b1;
        serve_issue();
        rd_req = 1'b0;
        serve_done(1'b0, 0);
      end else begin
        push_cmd(1'b1, 32'h0002_0000 + 32'(i), 8'(i));
        wr_addr = 32'h0002_0000 + 32'(i); wr_len = 8'(i); wr_req = 1'b1;
        serve_issue();
        wr_req = 1'b0;
        serve_done(1'b1, 0);
      end
    end
    chk("t6_rd_count", stat_rd_bursts, 3);
    chk("t6_wr_count", stat_wr_bursts, 2);
    rst = 1'b1;
    #1;
    chk("t6_rd_after_rst", stat_rd_bursts, 0);
    chk("t6_wr_after_rst", stat_wr_bursts, 0);
    @(posedge fclk); #1;
    rst = 1'b0;
`endif

    repeat (3) @(posedge fclk);
    #1;
    chk("cmd_queue_drained", exp_cmd_q.size(), 0);
    chk("done_queue_drained", exp_done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
